// File: rtl/pci_master32_arb_if.sv
// Bundle of the W/R channel ports and the PCI master backend port for pci_master32_arb.
// The master modport is the arbiter's view; slave is the channel/master environment's view.
interface pci_master32_arb_if;
    // W (posted-write) channel
    logic        w_req_i;
    logic        w_rdy_i;
    logic        w_last_i;
    logic [31:0] w_address_i;
    logic [3:0]  w_bc_i;
    logic [3:0]  w_be_i;
    logic [31:0] w_data_i;
    logic        w_gnt_o;
    logic [3:0]  w_status_o;
    // R (delayed-read) channel
    logic        r_req_i;
    logic        r_rdy_i;
    logic        r_last_i;
    logic [31:0] r_address_i;
    logic [3:0]  r_bc_i;
    logic [3:0]  r_be_i;
    logic [31:0] r_data_o;
    logic        r_gnt_o;
    logic [3:0]  r_status_o;
    // PCI master backend
    logic        req_o;
    logic        rdy_o;
    logic        last_o;
    logic [31:0] address_o;
    logic [3:0]  bc_o;
    logic [3:0]  be_o;
    logic [31:0] data_o;
    logic [3:0]  status_i;
    logic [31:0] data_i;

    modport master (
        input  w_req_i, w_rdy_i, w_last_i, w_address_i, w_bc_i, w_be_i, w_data_i,
        output w_gnt_o, w_status_o,
        input  r_req_i, r_rdy_i, r_last_i, r_address_i, r_bc_i, r_be_i,
        output r_data_o, r_gnt_o, r_status_o,
        output req_o, rdy_o, last_o, address_o, bc_o, be_o, data_o,
        input  status_i, data_i
    );

    modport slave (
        output w_req_i, w_rdy_i, w_last_i, w_address_i, w_bc_i, w_be_i, w_data_i,
        input  w_gnt_o, w_status_o,
        output r_req_i, r_rdy_i, r_last_i, r_address_i, r_bc_i, r_be_i,
        input  r_data_o, r_gnt_o, r_status_o,
        input  req_o, rdy_o, last_o, address_o, bc_o, be_o, data_o,
        output status_i, data_i
    );
endinterface

// File: rtl/pci_master32_arb.sv
// Round-robin arbiter sharing the PCI master backend between a posted-write (W) and a
// delayed-read (R) channel, with a per-channel holdoff after RETRY/DISCONNECT_WO_DATA.
module pci_master32_arb #(
    parameter logic [7:0] RETRY_HOLDOFF = 8'd8
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    pci_master32_arb_if.master    bus
);
    localparam logic [3:0] ST_WAIT       = 4'd0;
    localparam logic [3:0] ST_TRANSFERED = 4'd1;
    localparam logic [3:0] ST_DISC_WO_D  = 4'd2;
    localparam logic [3:0] ST_DISC_W_D   = 4'd3;
    localparam logic [3:0] ST_TABORT     = 4'd4;
    localparam logic [3:0] ST_MABORT     = 4'd5;
    localparam logic [3:0] ST_RETRY      = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GNT_W,
        S_GNT_R,
        S_RELEASE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_served_r;     // 1: R was served last, so W wins the next tie
    logic [7:0] r_hold_w;
    logic [7:0] r_hold_r;

    logic w_elig_w;
    logic w_elig_r;
    logic w_backoff;
    logic w_abort;
    logic w_term_w;
    logic w_term_r;

    always_comb begin
        w_elig_w  = bus.w_req_i && (r_hold_w == '0);
        w_elig_r  = bus.r_req_i && (r_hold_r == '0);
        w_backoff = (bus.status_i == ST_RETRY) || (bus.status_i == ST_DISC_WO_D);
        w_abort   = w_backoff || (bus.status_i == ST_TABORT) || (bus.status_i == ST_MABORT);
        // DISCONNECT_W_DATA ends the grant whether or not it was the last beat
        w_term_w  = w_abort || (bus.status_i == ST_DISC_W_D) || !bus.w_req_i ||
                    ((bus.status_i == ST_TRANSFERED) && bus.w_last_i && bus.w_rdy_i);
        w_term_r  = w_abort || (bus.status_i == ST_DISC_W_D) || !bus.r_req_i ||
                    ((bus.status_i == ST_TRANSFERED) && bus.r_last_i && bus.r_rdy_i);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_elig_w && (!w_elig_r || r_served_r)) begin
                    w_next = S_GNT_W;
                end else if (w_elig_r) begin
                    w_next = S_GNT_R;
                end
            end
            S_GNT_W:   if (w_term_w) w_next = S_RELEASE;
            S_GNT_R:   if (w_term_r) w_next = S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state    <= S_IDLE;
            r_served_r <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == S_GNT_W && w_next != S_GNT_W) begin
                r_served_r <= 1'b0;
            end else if (r_state == S_GNT_R && w_next != S_GNT_R) begin
                r_served_r <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_hold_w <= '0;
            r_hold_r <= '0;
        end else begin
            if (r_state == S_GNT_W && w_backoff) begin
                r_hold_w <= RETRY_HOLDOFF;
            end else if (r_hold_w != '0) begin
                r_hold_w <= r_hold_w - 8'd1;
            end
            if (r_state == S_GNT_R && w_backoff) begin
                r_hold_r <= RETRY_HOLDOFF;
            end else if (r_hold_r != '0) begin
                r_hold_r <= r_hold_r - 8'd1;
            end
        end
    end

    always_comb begin
        bus.w_gnt_o    = (r_state == S_GNT_W);
        bus.r_gnt_o    = (r_state == S_GNT_R);
        bus.r_data_o   = bus.data_i;
        bus.req_o      = 1'b0;
        bus.rdy_o      = 1'b0;
        bus.last_o     = 1'b0;
        bus.address_o  = '0;
        bus.bc_o       = '0;
        bus.be_o       = '0;
        bus.data_o     = '0;
        bus.w_status_o = ST_WAIT;
        bus.r_status_o = ST_WAIT;
        case (r_state)
            S_GNT_W: begin
                bus.req_o      = bus.w_req_i;
                bus.rdy_o      = bus.w_rdy_i;
                bus.last_o     = bus.w_last_i;
                bus.address_o  = bus.w_address_i;
                bus.bc_o       = bus.w_bc_i;
                bus.be_o       = bus.w_be_i;
                bus.data_o     = bus.w_data_i;
                bus.w_status_o = bus.status_i;
            end
            S_GNT_R: begin
                bus.req_o      = bus.r_req_i;
                bus.rdy_o      = bus.r_rdy_i;
                bus.last_o     = bus.r_last_i;
                bus.address_o  = bus.r_address_i;
                bus.bc_o       = bus.r_bc_i;
                bus.be_o       = bus.r_be_i;
                bus.r_status_o = bus.status_i;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pci_master32_arb.sv
// Directed bench for pci_master32_arb: per-cycle expectations are queued by the stimulus
// process and compared by a negedge monitor.
module tb_pci_master32_arb;
    localparam logic [3:0] ST_WAIT   = 4'd0;
    localparam logic [3:0] ST_XFER   = 4'd1;
    localparam logic [3:0] ST_DWO    = 4'd2;
    localparam logic [3:0] ST_DWD    = 4'd3;
    localparam logic [3:0] ST_TABORT = 4'd4;
    localparam logic [3:0] ST_MABORT = 4'd5;
    localparam logic [3:0] ST_RETRY  = 4'd6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pci_master32_arb_if bus();

    pci_master32_arb #(.RETRY_HOLDOFF(8'd8)) dut (
        .clk_in   (clk),
        .reset_in (rst_n),
        .bus      (bus)
    );

    typedef struct {
        string        tag;
        logic [116:0] v;
    } exp_t;

    exp_t         q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         m_e;
    logic [116:0] m_act;

    // Expected outputs for the current cycle given which channel (if any) holds the grant
    function automatic logic [116:0] pack_exp(input logic wg, input logic rg);
        logic        req, rdy, last;
        logic [31:0] a, d;
        logic [3:0]  bc, be, ws, rs;
        req = 1'b0; rdy = 1'b0; last = 1'b0;
        a = '0; d = '0; bc = '0; be = '0;
        ws = ST_WAIT; rs = ST_WAIT;
        if (wg) begin
            req = bus.w_req_i; rdy = bus.w_rdy_i; last = bus.w_last_i;
            a = bus.w_address_i; bc = bus.w_bc_i; be = bus.w_be_i; d = bus.w_data_i;
            ws = bus.status_i;
        end else if (rg) begin
            req = bus.r_req_i; rdy = bus.r_rdy_i; last = bus.r_last_i;
            a = bus.r_address_i; bc = bus.r_bc_i; be = bus.r_be_i;
            rs = bus.status_i;
        end
        return {wg, rg, req, rdy, last, a, bc, be, d, bus.data_i, ws, rs};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic wg, input logic rg);
        exp_t e;
        e.tag = tag;
        e.v   = pack_exp(wg, rg);
        q.push_back(e);
        tick();
    endtask

    task automatic drv_w(input logic req, input logic rdy, input logic last);
        bus.w_req_i = req; bus.w_rdy_i = rdy; bus.w_last_i = last;
    endtask

    task automatic drv_r(input logic req, input logic rdy, input logic last);
        bus.r_req_i = req; bus.r_rdy_i = rdy; bus.r_last_i = last;
    endtask

    // Single-requester transaction that ends on one terminal status
    task automatic term_case(input logic is_w, input logic [3:0] st, input string tag);
        if (is_w) drv_w(1'b1, 1'b0, 1'b0); else drv_r(1'b1, 1'b0, 1'b0);
        bus.status_i = ST_WAIT;
        cyc({tag, "_idle"}, 1'b0, 1'b0);
        if (is_w) drv_w(1'b1, 1'b1, 1'b0); else drv_r(1'b1, 1'b1, 1'b0);
        bus.status_i = st;
        cyc(tag, is_w, !is_w);
        drv_w(1'b0, 1'b0, 1'b0); drv_r(1'b0, 1'b0, 1'b0);
        bus.status_i = ST_WAIT;
        cyc({tag, "_rel"}, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            m_e   = q.pop_front();
            m_act = {bus.w_gnt_o, bus.r_gnt_o, bus.req_o, bus.rdy_o, bus.last_o,
                     bus.address_o, bus.bc_o, bus.be_o, bus.data_o, bus.r_data_o,
                     bus.w_status_o, bus.r_status_o};
            n_tests++;
            if (m_act !== m_e.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", m_e.tag, m_act, m_e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drv_w(1'b0, 1'b0, 1'b0);
        drv_r(1'b0, 1'b0, 1'b0);
        bus.w_address_i = '0; bus.w_bc_i = '0; bus.w_be_i = '0; bus.w_data_i = '0;
        bus.r_address_i = '0; bus.r_bc_i = '0; bus.r_be_i = '0;
        bus.status_i = ST_WAIT;
        bus.data_i   = 32'h1234_5678;
        tick();

        // reset state, with r_data_o following data_i
        cyc("reset_state", 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc("post_reset_idle", 1'b0, 1'b0);

        // simultaneous request: W wins, R granted 3 cycles after W's terminal beat
        bus.w_address_i = 32'h1000_0040; bus.w_bc_i = 4'h7; bus.w_be_i = 4'hF;
        bus.w_data_i    = 32'hDEAD_BEEF;
        bus.r_address_i = 32'h3000_0008; bus.r_bc_i = 4'h6; bus.r_be_i = 4'hF;
        bus.data_i = '0;
        drv_w(1'b1, 1'b0, 1'b0); drv_r(1'b1, 1'b0, 1'b0);
        cyc("tie_idle", 1'b0, 1'b0);
        drv_w(1'b1, 1'b1, 1'b1); bus.status_i = ST_XFER;
        cyc("w_single", 1'b1, 1'b0);
        drv_w(1'b0, 1'b0, 1'b0); bus.status_i = ST_WAIT;
        cyc("tie_release", 1'b0, 1'b0);
        cyc("tie_gap_idle", 1'b0, 1'b0);
        drv_r(1'b1, 1'b1, 1'b1); bus.status_i = ST_XFER; bus.data_i = 32'hA5A5_0001;
        cyc("r_after_tie", 1'b0, 1'b1);
        drv_r(1'b0, 1'b0, 1'b0); bus.status_i = ST_WAIT;
        cyc("r_release", 1'b0, 1'b0);
        cyc("r_idle", 1'b0, 1'b0);

        // R 4-beat burst
        bus.r_address_i = 32'h2000_0100; bus.r_bc_i = 4'h6; bus.r_be_i = 4'hC;
        drv_r(1'b1, 1'b0, 1'b0);
        cyc("burst_idle", 1'b0, 1'b0);
        for (int unsigned i = 1; i <= 4; i++) begin
            drv_r(1'b1, 1'b1, (i == 4));
            bus.status_i = ST_XFER;
            bus.data_i   = i;
            cyc($sformatf("burst_beat%0d", i), 1'b0, 1'b1);
        end
        drv_r(1'b0, 1'b0, 1'b0); bus.status_i = ST_WAIT; bus.data_i = '0;
        cyc("burst_release", 1'b0, 1'b0);
        cyc("burst_idle2", 1'b0, 1'b0);

        // W retried while R waits: R served at k+3, W held off until k+10
        bus.w_address_i = 32'h1000_0080; bus.w_data_i = 32'h0BAD_F00D;
        bus.r_address_i = 32'h3000_0010; bus.r_be_i = 4'hF;
        drv_w(1'b1, 1'b0, 1'b0); drv_r(1'b1, 1'b0, 1'b0);
        cyc("hold_tie", 1'b0, 1'b0);
        bus.status_i = ST_RETRY;
        cyc("w_retry", 1'b1, 1'b0);
        bus.status_i = ST_WAIT;
        cyc("retry_release", 1'b0, 1'b0);
        cyc("retry_idle", 1'b0, 1'b0);
        drv_r(1'b1, 1'b1, 1'b1); bus.status_i = ST_XFER;
        cyc("r_during_hold", 1'b0, 1'b1);
        drv_r(1'b0, 1'b0, 1'b0); bus.status_i = ST_WAIT;
        cyc("r_hold_release", 1'b0, 1'b0);
        for (int unsigned i = 0; i < 5; i++) begin
            cyc($sformatf("w_holdoff_idle%0d", i), 1'b0, 1'b0);
        end
        drv_w(1'b1, 1'b1, 1'b1); bus.status_i = ST_XFER;
        cyc("w_after_hold", 1'b1, 1'b0);
        drv_w(1'b0, 1'b0, 1'b0); bus.status_i = ST_WAIT;
        cyc("w_hold_release", 1'b0, 1'b0);
        cyc("w_hold_idle", 1'b0, 1'b0);

        // both channels retried back-to-back; R (earlier expiry) granted first
        drv_w(1'b1, 1'b0, 1'b0); drv_r(1'b1, 1'b0, 1'b0);
        cyc("bb_idle", 1'b0, 1'b0);
        bus.status_i = ST_RETRY;
        cyc("bb_r_retry", 1'b0, 1'b1);
        bus.status_i = ST_WAIT;
        cyc("bb_rel1", 1'b0, 1'b0);
        cyc("bb_idle1", 1'b0, 1'b0);
        bus.status_i = ST_RETRY;
        cyc("bb_w_retry", 1'b1, 1'b0);
        bus.status_i = ST_WAIT;
        cyc("bb_rel2", 1'b0, 1'b0);
        for (int unsigned i = 0; i < 5; i++) begin
            cyc($sformatf("bb_hold_idle%0d", i), 1'b0, 1'b0);
        end
        drv_r(1'b1, 1'b1, 1'b1); bus.status_i = ST_XFER;
        cyc("bb_r_grant", 1'b0, 1'b1);
        drv_r(1'b0, 1'b0, 1'b0); bus.status_i = ST_WAIT;
        cyc("bb_rel3", 1'b0, 1'b0);
        cyc("bb_idle3", 1'b0, 1'b0);
        drv_w(1'b1, 1'b1, 1'b1); bus.status_i = ST_XFER;
        cyc("bb_w_grant", 1'b1, 1'b0);
        drv_w(1'b0, 1'b0, 1'b0); bus.status_i = ST_WAIT;
        cyc("bb_rel4", 1'b0, 1'b0);
        cyc("bb_idle4", 1'b0, 1'b0);

        // asynchronous reset during GNT_R, then a fresh tie goes to W
        drv_r(1'b1, 1'b0, 1'b0);
        cyc("rst_idle", 1'b0, 1'b0);
        drv_r(1'b1, 1'b1, 1'b0); bus.status_i = ST_XFER; bus.data_i = 32'h1111_2222;
        cyc("r_beat_pre_reset", 1'b0, 1'b1);
        bus.data_i = 32'hCAFE_F00D;
        #1 rst_n = 1'b0;
        cyc("async_reset", 1'b0, 1'b0);
        cyc("reset_hold", 1'b0, 1'b0);
        rst_n = 1'b1;
        drv_r(1'b1, 1'b0, 1'b0); drv_w(1'b1, 1'b0, 1'b0); bus.status_i = ST_WAIT;
        cyc("tie2_idle", 1'b0, 1'b0);
        drv_w(1'b1, 1'b1, 1'b1); bus.status_i = ST_XFER;
        cyc("tie2_w", 1'b1, 1'b0);
        drv_w(1'b0, 1'b0, 1'b0); drv_r(1'b0, 1'b0, 1'b0); bus.status_i = ST_WAIT;
        cyc("tie2_rel", 1'b0, 1'b0);

        // remaining terminal conditions
        term_case(1'b1, ST_TABORT, "w_tabort");
        term_case(1'b0, ST_DWD,    "r_dwd_short");
        term_case(1'b1, ST_MABORT, "w_mabort");
        term_case(1'b0, ST_DWO,    "r_dwo");
        drv_w(1'b1, 1'b0, 1'b0);
        cyc("drop_idle", 1'b0, 1'b0);
        drv_w(1'b0, 1'b0, 1'b0);
        cyc("w_req_drop", 1'b1, 1'b0);
        cyc("drop_rel", 1'b0, 1'b0);
        cyc("drop_idle2", 1'b0, 1'b0);

        tick();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
